// File: rtl/trace_pkg_v12.sv
// Shared types for the latency-attribution trace packer: record layout, beat states, saturating adder.
// ATTR_PACKER_TIMESTAMP_EN adds a 64-bit capture timestamp to each record and a leading TS beat.
package trace_pkg_v12;

  typedef struct packed {
`ifdef ATTR_PACKER_TIMESTAMP_EN
    logic [63:0] ts;
`endif
    logic [31:0] seq;
    logic [31:0] total;
    logic [31:0] d_ingress;
    logic [31:0] d_core;
    logic [31:0] d_risk;
    logic [31:0] d_egress;
  } attr_record_t;

`ifdef ATTR_PACKER_TIMESTAMP_EN
  localparam int ATTR_BEATS = 4;
`else
  localparam int ATTR_BEATS = 3;
`endif

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_B0   = 3'd1,
    S_B1   = 3'd2,
    S_B2   = 3'd3
`ifdef ATTR_PACKER_TIMESTAMP_EN
    , S_TS = 3'd4
`endif
  } attr_beat_t;

  // Four-way add carried at 34 bits so any overflow clamps to all-ones.
  function automatic logic [31:0] sat_add32(input logic [31:0] a, input logic [31:0] b,
                                            input logic [31:0] c, input logic [31:0] d);
    logic [33:0] s;
    s = {2'b00, a} + {2'b00, b} + {2'b00, c} + {2'b00, d};
    return (s[33:32] != 2'b00) ? 32'hFFFF_FFFF : s[31:0];
  endfunction

endpackage

// File: rtl/attr_fifo.sv
// Synchronous first-word-fall-through FIFO of whole trace records.
// A push while full is accepted only when a pop happens in the same cycle.
module attr_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_data,
  input  logic                     i_pop,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_level,
  output logic [WIDTH-1:0]         o_head,
  output logic [WIDTH-1:0]         o_head_next
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE   = 1;
  localparam logic [AW:0]   LVL_ONE   = 1;
  localparam logic [AW:0]   LVL_DEPTH = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_level;
  logic             w_do_push;
  logic             w_do_pop;
  logic [AW-1:0]    w_rd_next;

  assign o_full      = (r_level == LVL_DEPTH);
  assign o_empty     = (r_level == '0);
  assign o_level     = r_level;
  assign w_do_push   = i_push & (~o_full | i_pop);
  assign w_do_pop    = i_pop & ~o_empty;
  assign w_rd_next   = r_rd_ptr + PTR_ONE;
  assign o_head      = r_mem[r_rd_ptr];
  // Lets the consumer preload the following record on the same edge it pops.
  assign o_head_next = r_mem[w_rd_next];

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_do_pop)  r_rd_ptr <= w_rd_next;
      case ({w_do_push, w_do_pop})
        2'b10:   r_level <= r_level + LVL_ONE;
        2'b01:   r_level <= r_level - LVL_ONE;
        default: r_level <= r_level;
      endcase
    end
  end

endmodule

// File: rtl/attr_trace_packer.sv
// Stamps attribution pulses with seq/total, queues them, and streams each record as 64-bit beats.
// ATTR_PACKER_TIMESTAMP_EN adds a free-running cycle stamp sent as a TS beat ahead of B0.
module attr_trace_packer
  import trace_pkg_v12::*;
#(
  parameter int DEPTH = 16,
  parameter int CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     attr_valid,
  input  logic [31:0]              attr_d_ingress,
  input  logic [31:0]              attr_d_core,
  input  logic [31:0]              attr_d_risk,
  input  logic [31:0]              attr_d_egress,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [63:0]              out_data,
  output logic                     out_last,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic [CNT_W-1:0]         drop_count
);

  // Handshake: a beat transfers on a rising edge with out_valid & out_ready; while
  // valid is high and ready low, out_data/out_last hold and valid does not drop.

  localparam logic [$clog2(DEPTH):0] LVL_ONE = 1;
  localparam logic [CNT_W-1:0]       CNT_ONE = 1;
`ifdef ATTR_PACKER_TIMESTAMP_EN
  localparam attr_beat_t S_FIRST = S_TS;
`else
  localparam attr_beat_t S_FIRST = S_B0;
`endif

  attr_beat_t             r_state;
  attr_beat_t             w_next_state;
  logic [31:0]            r_seq;
  logic [CNT_W-1:0]       r_drop_count;
  logic [63:0]            r_out_data;
  logic                   r_out_last;
  attr_record_t           w_in_rec;
  attr_record_t           w_head;
  attr_record_t           w_head_next;
  attr_record_t           w_load_rec;
  logic                   w_pop;
  logic                   w_full;
  logic                   w_empty;
  logic                   w_drop;
  logic [$clog2(DEPTH):0] w_level;
`ifdef ATTR_PACKER_TIMESTAMP_EN
  logic [63:0]            r_ts;
`endif

  function automatic logic [63:0] beat_of(input attr_record_t rec, input attr_beat_t st);
    case (st)
`ifdef ATTR_PACKER_TIMESTAMP_EN
      S_TS:    return rec.ts;
`endif
      S_B0:    return {rec.seq, rec.total};
      S_B1:    return {rec.d_ingress, rec.d_core};
      S_B2:    return {rec.d_risk, rec.d_egress};
      default: return 64'd0;
    endcase
  endfunction

  always_comb begin
    w_in_rec           = '0;
    w_in_rec.seq       = r_seq;
    w_in_rec.total     = sat_add32(attr_d_ingress, attr_d_core, attr_d_risk, attr_d_egress);
    w_in_rec.d_ingress = attr_d_ingress;
    w_in_rec.d_core    = attr_d_core;
    w_in_rec.d_risk    = attr_d_risk;
    w_in_rec.d_egress  = attr_d_egress;
`ifdef ATTR_PACKER_TIMESTAMP_EN
    w_in_rec.ts        = r_ts;
`endif
  end

  attr_fifo #(.WIDTH($bits(attr_record_t)), .DEPTH(DEPTH)) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_push      (attr_valid),
    .i_data      (w_in_rec),
    .i_pop       (w_pop),
    .o_full      (w_full),
    .o_empty     (w_empty),
    .o_level     (w_level),
    .o_head      (w_head),
    .o_head_next (w_head_next)
  );

  always_comb begin
    w_next_state = r_state;
    w_load_rec   = w_head;
    w_pop        = 1'b0;
    case (r_state)
      S_IDLE: if (!w_empty) w_next_state = S_FIRST;
`ifdef ATTR_PACKER_TIMESTAMP_EN
      S_TS:   if (out_ready) w_next_state = S_B0;
`endif
      S_B0:   if (out_ready) w_next_state = S_B1;
      S_B1:   if (out_ready) w_next_state = S_B2;
      S_B2: begin
        if (out_ready) begin
          w_pop = 1'b1;
          // Next record is either already queued behind the head or arriving this edge.
          if ((w_level > LVL_ONE) || attr_valid) begin
            w_next_state = S_FIRST;
            w_load_rec   = (w_level > LVL_ONE) ? w_head_next : w_in_rec;
          end else begin
            w_next_state = S_IDLE;
          end
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  assign w_drop = attr_valid & w_full & ~w_pop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_out_data   <= '0;
      r_out_last   <= 1'b0;
      r_seq        <= '0;
      r_drop_count <= '0;
    end else begin
      r_state    <= w_next_state;
      r_out_data <= beat_of(w_load_rec, w_next_state);
      r_out_last <= (w_next_state == S_B2);
      if (attr_valid) r_seq <= r_seq + 32'd1;
      if (w_drop && (r_drop_count != '1)) r_drop_count <= r_drop_count + CNT_ONE;
    end
  end

`ifdef ATTR_PACKER_TIMESTAMP_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_ts <= '0;
    else        r_ts <= r_ts + 64'd1;
  end
`endif

  assign out_valid  = (r_state != S_IDLE);
  assign out_data   = r_out_data;
  assign out_last   = r_out_last;
  assign fifo_level = w_level;
  assign drop_count = r_drop_count;

endmodule
